settle_meter: RTL and testbench
===============================

Name: settle_meter

Overview:
- Reads the output of a delayed-gate combinational network (AND arrays, ripple adders built from delayed primitives). It is the sequential stimulus/measurement end for those gates.
- On start it latches two operands and drives them into the network. It then samples the network output every clock and reports how many cycles the output took to settle, plus the settled value.
- Used in lab benches and on-board to measure propagation delay of gate chains in clock cycles.

Parameters:
WIDTH, 8, operand/result width in bits
CW, 8, width of cycle counters and settle_cycles
STABLE_CYCLES, 3, consecutive unchanged samples required to declare settled (1..MAX_WAIT-1)
MAX_WAIT, 255, samples taken before timeout (must be <= 2^CW-1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin measurement; sampled only in IDLE
a_in  input  WIDTH  operand A, latched on accepted start
b_in  input  WIDTH  operand B, latched on accepted start
drive_a  output  WIDTH  registered operand A to the gate network
drive_b  output  WIDTH  registered operand B to the gate network
dut_out  input  WIDTH  gate network output (combinational, delayed)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, results valid
timeout  output  1  held with results; 1 = output never settled
settle_cycles  output  CW  sample index of last output change (0 = never changed)
result  output  WIDTH  settled (or final, on timeout) dut_out value

Behaviour:
- Reset (async assert, sync-released by clk): state IDLE. drive_a, drive_b, result, settle_cycles, the sample counter k and the last-change index all = 0. busy, done and timeout = 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, WATCH, DONE.
- IDLE, start=1 at an edge:
  - drive_a<=a_in, drive_b<=b_in.
  - prev<=dut_out (sample 0, pre-apply snapshot).
  - k<=0, last<=0, timeout<=0, state<=WATCH.
  - result and settle_cycles hold their old values until the next done.
- WATCH, each edge, with k' = k+1 (sample index):
  - If dut_out != prev: last<=k'.
  - prev<=dut_out; k<=k'.
  - Settled test: k' - last_eff >= STABLE_CYCLES, where last_eff is k' if a change occurs this edge, else last.
  - If settled: result<=dut_out, settle_cycles<=last_eff, timeout<=0, state<=DONE.
  - Else if k' == MAX_WAIT: result<=dut_out, settle_cycles<=MAX_WAIT, timeout<=1, state<=DONE.
  - Settled and k'==MAX_WAIT on the same edge: success wins, timeout=0.
- DONE: done=1 for exactly this cycle, then state<=IDLE. start during DONE is ignored.
- start while busy is ignored; drive_a/drive_b stay stable throughout WATCH.
- Counter arithmetic is unsigned, CW bits. k never exceeds MAX_WAIT, so there is no wrap.
- Latency from start edge to done high = (settle index + STABLE_CYCLES) + 1 cycles, or MAX_WAIT+1 on timeout.
- drive_a/drive_b hold their values after completion until the next accepted start or reset.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately, without waiting for a clk edge; release -> IDLE, busy=0.
- Delay model L=2 (dut_out = drive_a&drive_b through a 2-stage register pipe), drives previously 0. Start with a_in=8'hF0, b_in=8'h3C:
  - result=8'h30, settle_cycles=2, timeout=0.
  - done high in the cycle after sample 5.
- Repeat the same operands -> no change seen: settle_cycles=0, result=8'h30, done after sample 3.
- Toggling model (dut_out inverts every cycle) -> timeout=1, settle_cycles=255, done after 255 samples + 1.
- start pulsed during WATCH with a_in=8'hFF -> ignored: drive_a unchanged, one done only.
- rst_n low during WATCH -> drive_a/drive_b=0, no done pulse. A subsequent start then measures normally.

Source files
------------

// File: rtl/settle_meter.sv
// Settle-time meter: drives two latched operands into a delayed gate network,
// samples its output every clock and reports how many cycles it took to settle.
module settle_meter #(
    parameter int WIDTH         = 8,
    parameter int CW            = 8,
    parameter int STABLE_CYCLES = 3,
    parameter int MAX_WAIT      = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] drive_a,
    output logic [WIDTH-1:0] drive_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CW-1:0]    settle_cycles,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    k;
    logic [CW-1:0]    last;

    logic [CW-1:0]    k_next;
    logic [CW-1:0]    last_eff;
    logic             changed;
    logic             settled;
    logic             at_limit;

    // NOTE: every variable gets a value on every pass so no latch is inferred.
    always_comb begin
        k_next   = k + CW'(1);
        changed  = (dut_out != prev);
        last_eff = changed ? k_next : last;
        settled  = (k_next - last_eff) >= CW'(STABLE_CYCLES);
        at_limit = (k_next == CW'(MAX_WAIT));
    end

    // Both flags decode straight from the state register, so reset clears them at once.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others within the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            drive_a       <= '0;
            drive_b       <= '0;
            prev          <= '0;
            k             <= '0;
            last          <= '0;
            result        <= '0;
            settle_cycles <= '0;
            timeout       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        drive_a <= a_in;
                        drive_b <= b_in;
                        prev    <= dut_out;
                        k       <= '0;
                        last    <= '0;
                        timeout <= 1'b0;
                        state   <= WATCH;
                    end
                end
                WATCH: begin
                    if (changed) last <= k_next;
                    prev <= dut_out;
                    k    <= k_next;
                    // A settle on the final sample still counts as success.
                    if (settled) begin
                        result        <= dut_out;
                        settle_cycles <= last_eff;
                        timeout       <= 1'b0;
                        state         <= DONE;
                    end else if (at_limit) begin
                        result        <= dut_out;
                        settle_cycles <= CW'(MAX_WAIT);
                        timeout       <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_settle_meter.sv
// Directed bench for settle_meter: a two-register AND network and a toggling
// network stand in for the delayed gate chain.
module tb_settle_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic [7:0] drive_a;
    logic [7:0] drive_b;
    logic [7:0] dut_out;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] settle_cycles;
    logic [7:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int done_count = 0;

    // Network models: mode 0 = drive register + one pipe stage (L=2), mode 1 = toggler.
    logic       mode = 1'b0;
    logic [7:0] p1 = 8'h00;
    logic [7:0] tog = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1  <= drive_a & drive_b;
        tog <= ~tog;
    end

    assign dut_out = mode ? tog : p1;

    always @(negedge clk) if (done === 1'b1) done_count++;

    settle_meter #(
        .WIDTH(8), .CW(8), .STABLE_CYCLES(3), .MAX_WAIT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .drive_a(drive_a), .drive_b(drive_b), .dut_out(dut_out),
        .busy(busy), .done(done), .timeout(timeout),
        .settle_cycles(settle_cycles), .result(result)
    );

    // Issues a start and counts edges (start edge included) until done is seen.
    task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b,
                                  input int budget, output int cycles);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({drive_a, drive_b, result, settle_cycles, busy, done, timeout} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_async: outputs=%h required 0",
                     {drive_a, drive_b, result, settle_cycles, busy, done, timeout});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_settle_l2;
        int cyc;
        int dc0;
        dc0 = done_count;
        start_and_wait(8'hF0, 8'h3C, 20, cyc);
        n_cmp++;
        if (cyc !== 6) begin
            n_bad++;
            $display("FAIL l2_latency: got %0d required 6", cyc);
        end
        n_cmp++;
        if (result !== 8'h30 || settle_cycles !== 8'd2 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL l2_results: result=%h settle=%0d timeout=%b required 30 2 0",
                     result, settle_cycles, timeout);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || done_count - dc0 !== 1) begin
            n_bad++;
            $display("FAIL l2_done_pulse: done=%b busy=%b pulses=%0d required 0 0 1",
                     done, busy, done_count - dc0);
        end
        n_cmp++;
        if (drive_a !== 8'hF0 || drive_b !== 8'h3C || result !== 8'h30) begin
            n_bad++;
            $display("FAIL l2_hold: drive_a=%h drive_b=%h result=%h required F0 3C 30",
                     drive_a, drive_b, result);
        end
    endtask

    task automatic test_no_change;
        int cyc;
        start_and_wait(8'hF0, 8'h3C, 20, cyc);
        n_cmp++;
        if (cyc !== 4) begin
            n_bad++;
            $display("FAIL nochange_latency: got %0d required 4", cyc);
        end
        n_cmp++;
        if (result !== 8'h30 || settle_cycles !== 8'd0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL nochange_results: result=%h settle=%0d timeout=%b required 30 0 0",
                     result, settle_cycles, timeout);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        @(negedge clk);
        mode = 1'b1;
        start_and_wait(8'h12, 8'h34, 300, cyc);
        n_cmp++;
        if (cyc !== 256) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d required 256", cyc);
        end
        // The last sample was taken just before the toggler flipped again.
        n_cmp++;
        if (timeout !== 1'b1 || settle_cycles !== 8'd255 || result !== ~tog) begin
            n_bad++;
            $display("FAIL timeout_results: timeout=%b settle=%0d result=%h required 1 255 %h",
                     timeout, settle_cycles, result, ~tog);
        end
        @(negedge clk);
        mode = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_start_ignored;
        int cyc;
        int dc0;
        dc0 = done_count;
        @(negedge clk);
        a_in  = 8'h0F;
        b_in  = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        n_cmp++;
        if (drive_a !== 8'h0F || drive_b !== 8'hFF || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_start_drive: drive_a=%h drive_b=%h busy=%b required 0F FF 1",
                     drive_a, drive_b, busy);
        end
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++;
        if (cyc !== 6 || result !== 8'h0F || settle_cycles !== 8'd2) begin
            n_bad++;
            $display("FAIL busy_start_result: cycles=%0d result=%h settle=%0d required 6 0F 2",
                     cyc, result, settle_cycles);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (done_count - dc0 !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_start_pulses: pulses=%0d busy=%b required 1 0",
                     done_count - dc0, busy);
        end
    endtask

    task automatic test_reset_in_watch;
        int cyc;
        int dc0;
        dc0 = done_count;
        @(negedge clk);
        a_in  = 8'hAA;
        b_in  = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (drive_a !== 8'h00 || drive_b !== 8'h00 || busy !== 1'b0 ||
            result !== 8'h00 || settle_cycles !== 8'd0) begin
            n_bad++;
            $display("FAIL watch_reset: drive_a=%h drive_b=%h busy=%b result=%h settle=%0d required 0",
                     drive_a, drive_b, busy, result, settle_cycles);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (done_count - dc0 !== 0) begin
            n_bad++;
            $display("FAIL watch_reset_nodone: pulses=%0d required 0", done_count - dc0);
        end
        start_and_wait(8'h55, 8'h0F, 20, cyc);
        n_cmp++;
        if (cyc !== 6 || result !== 8'h05 || settle_cycles !== 8'd2 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset_run: cycles=%0d result=%h settle=%0d timeout=%b required 6 05 2 0",
                     cyc, result, settle_cycles, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_settle_l2();
        test_no_change();
        test_timeout();
        test_start_ignored();
        test_reset_in_watch();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
